// File: rtl/riscv_cache_pkg.sv
// Shared cache definitions: controller states, default geometry and address-field helpers.
// The instruction cache imports the same package.
package riscv_cache_pkg;

    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_INDEX_BITS  = 8;
    localparam int DEF_OFFSET_BITS = 2;
    localparam int BYTE_BITS       = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL_REQ,
        REFILL_WAIT,
        RESP,
        WRITE
    } cache_state_t;

    function automatic int tag_bits(input int addr_width, input int index_bits, input int offset_bits);
        return addr_width - index_bits - offset_bits - BYTE_BITS;
    endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Cache data store: one write port, one registered read port.
// Read data appears the cycle after re; no backpressure.
module dcache_data_array #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/riscv_dcache.sv
// Direct-mapped write-through, no-write-allocate data cache; hits answer 2 cycles after cpu_req.
// One request in flight: cpu_ready drops until the strobe; mem_req holds until mem_ready.
module riscv_dcache
    import riscv_cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int INDEX_BITS  = DEF_INDEX_BITS,
    parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_din,
    output logic                  cpu_ready,
    output logic [31:0]           cpu_dout,
    output logic                  cpu_data_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    localparam int TAG_BITS  = tag_bits(ADDR_WIDTH, INDEX_BITS, OFFSET_BITS);
    localparam int WORD_BITS = ADDR_WIDTH - BYTE_BITS;
    localparam int RAM_AW    = INDEX_BITS + OFFSET_BITS;
    localparam int LINES     = 1 << INDEX_BITS;
    localparam logic [OFFSET_BITS-1:0] LAST_WORD = '1;

    cache_state_t state, state_nxt;

    logic [WORD_BITS-1:0]   req_word;
    logic [31:0]            req_din;
    logic [TAG_BITS-1:0]    req_tag;
    logic [INDEX_BITS-1:0]  req_idx;
    logic [OFFSET_BITS-1:0] req_off;
    logic [OFFSET_BITS-1:0] cnt;
    logic [31:0]            fill_word;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem [LINES];
    logic                tag_hit;

    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [31:0]       ram_wdata;
    logic              ram_re;
    logic [RAM_AW-1:0] ram_raddr;
    logic [31:0]       ram_rdata;

    logic unused_byte_bits;
    assign unused_byte_bits = ^cpu_addr[BYTE_BITS-1:0];

    assign req_tag = req_word[WORD_BITS-1 -: TAG_BITS];
    assign req_idx = req_word[OFFSET_BITS +: INDEX_BITS];
    assign req_off = req_word[OFFSET_BITS-1:0];
    assign tag_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    dcache_data_array #(
        .AW (RAM_AW),
        .DW (32)
    ) u_data_array (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_nxt = state;
        cpu_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ram_we    = 1'b0;
        ram_waddr = {req_idx, cnt};
        ram_wdata = mem_rdata;
        // The data read is launched from the raw request so LOOKUP sees it one cycle later.
        ram_re    = 1'b0;
        ram_raddr = cpu_addr[BYTE_BITS +: RAM_AW];
        case (state)
            IDLE: begin
                cpu_ready = 1'b1;
                ram_re    = cpu_req;
                if (cpu_req) begin
                    state_nxt = cpu_we ? WRITE : LOOKUP;
                end
            end
            LOOKUP: begin
                state_nxt = tag_hit ? IDLE : REFILL_REQ;
            end
            REFILL_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx, cnt, {BYTE_BITS{1'b0}}};
                if (mem_ready) begin
                    state_nxt = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                if (mem_rvalid) begin
                    ram_we    = 1'b1;
                    state_nxt = (cnt == LAST_WORD) ? RESP : REFILL_REQ;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {req_word, {BYTE_BITS{1'b0}}};
                mem_wdata = req_din;
                // Rewriting the same word while memory stalls is harmless.
                ram_we    = tag_hit;
                ram_waddr = {req_idx, req_off};
                ram_wdata = req_din;
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            req_word       <= '0;
            req_din        <= '0;
            cnt            <= '0;
            fill_word      <= '0;
            valid          <= '0;
            cpu_dout       <= '0;
            cpu_data_valid <= 1'b0;
        end else begin
            state          <= state_nxt;
            cpu_data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_word <= cpu_addr[ADDR_WIDTH-1:BYTE_BITS];
                        req_din  <= cpu_din;
                        cnt      <= '0;
                    end
                end
                LOOKUP: begin
                    if (tag_hit) begin
                        cpu_dout       <= ram_rdata;
                        cpu_data_valid <= 1'b1;
                    end
                end
                REFILL_WAIT: begin
                    if (mem_rvalid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == req_off) begin
                            fill_word <= mem_rdata;
                        end
                        if (cnt == LAST_WORD) begin
                            valid[req_idx] <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    cpu_dout       <= fill_word;
                    cpu_data_valid <= 1'b1;
                end
                WRITE: begin
                    if (mem_ready) begin
                        cpu_data_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tags need no reset: a line is only trusted once its valid flop is set.
    always_ff @(posedge clk) begin
        if (state == REFILL_WAIT && mem_rvalid && cnt == LAST_WORD) begin
            tag_mem[req_idx] <= req_tag;
        end
    end

endmodule

// File: tb/tb_riscv_dcache.sv
// Bench for riscv_dcache: directed scenarios plus random traffic against a line-level cache model.
// Memory responder adds random accept and read-return delays.
module tb_riscv_dcache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_din = '0;
    logic        cpu_ready;
    logic [31:0] cpu_dout;
    logic        cpu_data_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_dcache dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_din        (cpu_din),
        .cpu_ready      (cpu_ready),
        .cpu_dout       (cpu_dout),
        .cpu_data_valid (cpu_data_valid),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ready      (mem_ready),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
    );

    // ---------------- memory responder and bus monitor ----------------
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] rd_log [$];
    logic [31:0] wr_addr_log [$];
    logic [31:0] wr_data_log [$];
    int          strobe_cnt = 0;
    int          req_cycles = 0;
    int          rvalid_cnt = 0;
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = '0;
    logic        prev_req = 0, prev_ready = 0, prev_we = 0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mem_get(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return init_word(a);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            pend       = 0;
            prev_req   = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (cpu_data_valid) strobe_cnt++;
            if (mem_req) req_cycles++;
            if (prev_req && !prev_ready) begin
                checks++;
                if (!mem_req || mem_we !== prev_we || mem_addr !== prev_addr || mem_wdata !== prev_wdata) begin
                    failures++;
                    $display("FAIL mem_hold got req=%b we=%b addr=%h wdata=%h exp req=1 we=%b addr=%h wdata=%h",
                             mem_req, mem_we, mem_addr, mem_wdata, prev_we, prev_addr, prev_wdata);
                end
            end
            mem_rvalid = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_data;
                    pend       = 0;
                    rvalid_cnt++;
                end else begin
                    pend_cnt--;
                end
            end
            mem_ready = mem_req && ($urandom_range(0, 3) != 0);
            if (mem_ready) begin
                if (mem_we) begin
                    mem_arr[mem_addr] = mem_wdata;
                    wr_addr_log.push_back(mem_addr);
                    wr_data_log.push_back(mem_wdata);
                end else begin
                    rd_log.push_back(mem_addr);
                    pend      = 1;
                    pend_data = mem_get(mem_addr);
                    pend_cnt  = int'($urandom_range(0, 2));
                end
            end
            prev_req   = mem_req;
            prev_ready = mem_ready;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    // ---------------- reference model: line presence + flat memory ----------------
    bit          ref_valid [256];
    logic [19:0] ref_tag [256];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if (ref_mem.exists(w)) return ref_mem[w];
        return init_word(w);
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        return ref_valid[a[11:4]] && ref_tag[a[11:4]] == a[31:12];
    endfunction

    function automatic void ref_fill(input logic [31:0] a);
        ref_valid[a[11:4]] = 1;
        ref_tag[a[11:4]]   = a[31:12];
    endfunction

    function automatic void ref_clear();
        for (int i = 0; i < 256; i++) ref_valid[i] = 0;
    endfunction

    function automatic void preload(input logic [31:0] a, input logic [31:0] d);
        mem_arr[a] = d;
        ref_mem[a] = d;
    endfunction

    // ---------------- access driver (results only, no judging) ----------------
    logic [31:0] acc_dout;
    int          acc_lat, acc_nstr, acc_reqc, acc_rd_base, acc_wr_base;
    bit          acc_to;

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] din, input bit spam);
        int n, str0, req0;
        acc_to = 0;
        @(negedge clk); #1;
        n = 0;
        while (!cpu_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        acc_rd_base = rd_log.size();
        acc_wr_base = wr_addr_log.size();
        str0 = strobe_cnt;
        req0 = req_cycles;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
        @(negedge clk); #1;
        cpu_req = 1'b0;
        acc_lat = 1;
        n = 0;
        while (!cpu_data_valid) begin
            if (n >= 300) begin
                acc_to = 1;
                break;
            end
            if (spam) begin
                cpu_req  = 1'b1;
                cpu_we   = 1'($urandom_range(0, 1));
                cpu_addr = $urandom;
                cpu_din  = $urandom;
            end
            @(negedge clk); #1;
            acc_lat++;
            n++;
        end
        cpu_req  = 1'b0;
        acc_dout = cpu_dout;
        @(negedge clk); #1;
        acc_nstr = strobe_cnt - str0;
        acc_reqc = req_cycles - req0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++;
        if ({cpu_ready, cpu_data_valid, mem_req, mem_we} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_ctrl got ready/valid/req/we=%b exp=1000", {cpu_ready, cpu_data_valid, mem_req, mem_we});
        end
        checks++;
        if (cpu_dout !== 32'h0) begin
            failures++;
            $display("FAIL reset_dout got=%h exp=0", cpu_dout);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem_bus got addr=%h wdata=%h exp 0/0", mem_addr, mem_wdata);
        end
        ref_clear();
        rst = 1'b0;
    endtask

    task automatic test_cold_load();
        int nrd;
        for (int i = 0; i < 4; i++) preload(32'h1000 + 32'(4 * i), 32'hA0 + 32'(i));
        access(1'b0, 32'h1004, 32'h0, 0);
        nrd = rd_log.size() - acc_rd_base;
        checks++;
        if (acc_to || nrd != 4) begin
            failures++;
            $display("FAIL cold_reads got=%0d timeout=%0d exp=4", nrd, acc_to);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_log[acc_rd_base + i] !== 32'h1000 + 32'(4 * i)) begin
                    failures++;
                    $display("FAIL cold_read_addr%0d got=%h exp=%h", i, rd_log[acc_rd_base + i], 32'h1000 + 32'(4 * i));
                end
            end
        end
        checks++;
        if (acc_dout !== 32'hA1 || acc_nstr != 1) begin
            failures++;
            $display("FAIL cold_data got=%h strobes=%0d exp=000000a1 strobes=1", acc_dout, acc_nstr);
        end
        ref_fill(32'h1004);
    endtask

    task automatic test_hit_reload();
        access(1'b0, 32'h100C, 32'h0, 1);
        checks++;
        if (acc_lat != 2 || acc_reqc != 0 || acc_nstr != 1) begin
            failures++;
            $display("FAIL hit_timing got lat=%0d memreq_cycles=%0d strobes=%0d exp 2/0/1", acc_lat, acc_reqc, acc_nstr);
        end
        checks++;
        if (acc_dout !== 32'hA3) begin
            failures++;
            $display("FAIL hit_data got=%h exp=000000a3", acc_dout);
        end
    endtask

    task automatic test_store_hit();
        int nwr;
        access(1'b1, 32'h1008, 32'hDEADBEEF, 0);
        ref_mem[32'h1008] = 32'hDEADBEEF;
        nwr = wr_addr_log.size() - acc_wr_base;
        checks++;
        if (acc_to || nwr != 1 || acc_nstr != 1 || rd_log.size() != acc_rd_base) begin
            failures++;
            $display("FAIL store_hit_bus got writes=%0d strobes=%0d timeout=%0d exp 1/1/0", nwr, acc_nstr, acc_to);
        end else begin
            checks++;
            if (wr_addr_log[acc_wr_base] !== 32'h1008 || wr_data_log[acc_wr_base] !== 32'hDEADBEEF) begin
                failures++;
                $display("FAIL store_hit_write got=%h:%h exp=00001008:deadbeef", wr_addr_log[acc_wr_base], wr_data_log[acc_wr_base]);
            end
        end
        access(1'b0, 32'h1008, 32'h0, 0);
        checks++;
        if (acc_dout !== 32'hDEADBEEF || acc_lat != 2 || acc_reqc != 0) begin
            failures++;
            $display("FAIL store_hit_reload got=%h lat=%0d memreq_cycles=%0d exp=deadbeef 2 0", acc_dout, acc_lat, acc_reqc);
        end
    endtask

    task automatic test_store_miss();
        int nrd;
        access(1'b1, 32'h2000, 32'h1234_5678, 0);
        ref_mem[32'h2000] = 32'h1234_5678;
        checks++;
        if (wr_addr_log.size() - acc_wr_base != 1 || rd_log.size() != acc_rd_base) begin
            failures++;
            $display("FAIL store_miss_bus got writes=%0d reads=%0d exp 1/0",
                     wr_addr_log.size() - acc_wr_base, rd_log.size() - acc_rd_base);
        end
        access(1'b0, 32'h2000, 32'h0, 0);
        nrd = rd_log.size() - acc_rd_base;
        checks++;
        if (nrd != 4 || rd_log[acc_rd_base] !== 32'h2000 || acc_dout !== 32'h1234_5678) begin
            failures++;
            $display("FAIL store_no_allocate got reads=%0d data=%h exp reads=4 data=12345678", nrd, acc_dout);
        end
        ref_fill(32'h2000);
    endtask

    task automatic test_conflict();
        logic [31:0] seq [3];
        logic [31:0] a;
        seq[0] = 32'h1000; seq[1] = 32'h2000; seq[2] = 32'h1000;
        for (int k = 0; k < 3; k++) begin
            a = seq[k];
            access(1'b0, a, 32'h0, 0);
            checks++;
            if (rd_log.size() - acc_rd_base != 4 || acc_dout !== ref_get(a)) begin
                failures++;
                $display("FAIL conflict_load%0d got reads=%0d data=%h exp reads=4 data=%h",
                         k, rd_log.size() - acc_rd_base, acc_dout, ref_get(a));
            end
            ref_fill(a);
        end
    endtask

    task automatic test_reset_mid_refill();
        int n, s0, rv0;
        access(1'b0, 32'h1010, 32'h0, 0);
        ref_fill(32'h1010);
        @(negedge clk); #1;
        s0  = strobe_cnt;
        rv0 = rvalid_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3008;
        @(negedge clk); #1;
        cpu_req = 1'b0;
        n = 0;
        while (rvalid_cnt - rv0 < 2 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (rvalid_cnt - rv0 != 2) begin
            failures++;
            $display("FAIL midfill_progress got rvalids=%0d exp=2", rvalid_cnt - rv0);
        end
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (strobe_cnt != s0 || cpu_ready !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL midfill_abort got strobes=%0d ready=%b mem_req=%b exp 0/1/0", strobe_cnt - s0, cpu_ready, mem_req);
        end
        repeat (3) @(negedge clk);
        #1;
        ref_clear();
        rst = 1'b0;
        access(1'b0, 32'h3008, 32'h0, 0);
        checks++;
        if (rd_log.size() - acc_rd_base != 4 || rd_log[acc_rd_base] !== 32'h3000 ||
            rd_log[acc_rd_base + 3] !== 32'h300C || acc_dout !== ref_get(32'h3008) || acc_nstr != 1) begin
            failures++;
            $display("FAIL midfill_refill got reads=%0d data=%h strobes=%0d exp reads=4 data=%h strobes=1",
                     rd_log.size() - acc_rd_base, acc_dout, acc_nstr, ref_get(32'h3008));
        end
        ref_fill(32'h3008);
        access(1'b0, 32'h1010, 32'h0, 0);
        checks++;
        if (rd_log.size() - acc_rd_base != 4) begin
            failures++;
            $display("FAIL reset_clears_valid got reads=%0d exp=4", rd_log.size() - acc_rd_base);
        end
        ref_fill(32'h1010);
    endtask

    task automatic test_random();
        logic [31:0] tags [4];
        logic [31:0] idxs [3];
        logic [31:0] addr, waddr, din, base;
        logic        we;
        bit          exp_hit;
        int          nrd, nwr;
        tags[0] = 1; tags[1] = 2; tags[2] = 3; tags[3] = 5;
        idxs[0] = 0; idxs[1] = 1; idxs[2] = 7;
        for (int t = 0; t < 40; t++) begin
            addr  = (tags[$urandom_range(0, 3)] << 12) | (idxs[$urandom_range(0, 2)] << 4) |
                    32'($urandom_range(0, 15));
            waddr = addr & ~32'h3;
            base  = addr & ~32'hF;
            we    = 1'($urandom_range(0, 1));
            din   = $urandom;
            exp_hit = ref_hit(addr);
            access(we, addr, din, 1'($urandom_range(0, 1)));
            nrd = rd_log.size() - acc_rd_base;
            nwr = wr_addr_log.size() - acc_wr_base;
            checks++;
            if (acc_to || acc_nstr != 1) begin
                failures++;
                $display("FAIL rand%0d_strobe got strobes=%0d timeout=%0d exp 1/0", t, acc_nstr, acc_to);
            end
            if (we) begin
                ref_mem[waddr] = din;
                checks++;
                if (nwr != 1 || nrd != 0 || wr_addr_log[acc_wr_base] !== waddr || wr_data_log[acc_wr_base] !== din) begin
                    failures++;
                    $display("FAIL rand%0d_store got writes=%0d reads=%0d last=%h:%h exp 1/0 %h:%h",
                             t, nwr, nrd, wr_addr_log[wr_addr_log.size() - 1], wr_data_log[wr_data_log.size() - 1], waddr, din);
                end
            end else begin
                checks++;
                if (acc_dout !== ref_get(addr)) begin
                    failures++;
                    $display("FAIL rand%0d_load_data addr=%h got=%h exp=%h", t, addr, acc_dout, ref_get(addr));
                end
                checks++;
                if (exp_hit) begin
                    if (acc_lat != 2 || acc_reqc != 0) begin
                        failures++;
                        $display("FAIL rand%0d_hit got lat=%0d memreq_cycles=%0d exp 2/0", t, acc_lat, acc_reqc);
                    end
                end else if (nrd != 4 || rd_log[acc_rd_base] !== base || rd_log[acc_rd_base + 3] !== base + 32'hC) begin
                    failures++;
                    $display("FAIL rand%0d_miss got reads=%0d first=%h exp reads=4 first=%h", t, nrd, rd_log[acc_rd_base], base);
                end
                ref_fill(addr);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        test_cold_load();
        test_hit_reload();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_reset_mid_refill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
